multiword_sub_seq: RTL
======================

Name: multiword_sub_seq

Overview:
- Sequencer that reuses one WIDTH-bit ripple-borrow subtractor slice over WORDS cycles to compute a wide subtraction: (WIDTH*WORDS)-bit a - b - bin.
- Latches both operands on start, feeds one word per cycle from LSW to MSW, and chains the borrow through a register.
- Reports the difference, the final borrow-out and the two's-complement signed overflow.
- Serves as the area-saving wide subtractor for datapaths that cannot afford a full-width ripple chain.

Parameters:
- WIDTH, 4, bit width of the shared subtractor slice (one word).
- WORDS, 4, number of words per operand; total width N = WIDTH*WORDS; WORDS >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request; sampled only while idle
- a  in  N  minuend (unsigned or two's-complement)
- b  in  N  subtrahend
- bin  in  1  initial borrow-in applied to word 0
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: results are valid
- diff  out  N  a - b - bin, modulo 2^N
- bout  out  1  borrow out of the MSB (unsigned a < b + bin)
- overflow  out  1  signed overflow of the N-bit result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset state: IDLE, busy=0, done=0, diff=0, bout=0, overflow=0, word counter=0, borrow register=0, operand shift registers=0.
- FSM states are IDLE and RUN.
- IDLE:
  - On a clock edge with start=1, latch a, b and bin (bin goes into the borrow register), clear the counter, and enter RUN. busy=1 from the next cycle.
  - With start=0, stay in IDLE.
- RUN, one word per edge:
  - The slice takes the current low words of the a/b shift registers plus the borrow register.
  - The slice difference word shifts into the result register from the top.
  - The borrow register takes the slice borrow-out.
  - The a/b shift registers shift right by WIDTH.
  - The counter increments.
- Completion: on the edge that processes word WORDS-1:
  - Load diff from the assembled result and set bout to the final slice borrow-out.
  - Set overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]), using the latched operands.
  - Pulse done=1 for exactly one cycle, drop busy to 0, and return to IDLE.
- Latency: start sampled at edge k, then RUN edges k+1..k+WORDS. done, busy=0 and valid outputs appear after edge k+WORDS.
- Back-to-back: a start asserted during the done cycle is accepted. Throughput is one operation per WORDS+1 cycles.
- Output stability: diff, bout and overflow change only at completion or reset. Between those events they hold their values, including through the next operation's RUN phase.
- start while busy: ignored, not queued. The latched operands are used, so changes to a, b or bin during RUN have no effect.
- Reset mid-operation: abort, discard partial results, and return to the full reset state on that edge. No done pulse.
- bin applies to word 0 only. The borrow register is cleared on reset, not on completion, and is reloaded at the next start.
- Slice equations per bit: d = x^y^c; bo = (~x&y) | (~(x^y)&c).

Decomposition:
- Shared package:
  - FSM state typedef (IDLE, RUN).
  - Counter width constant $clog2(WORDS).
  - Default WIDTH and WORDS constants.
- One sub-module, sub_slice: combinational WIDTH-bit ripple-borrow subtractor built from per-bit full-subtractor cells.
  - Ports: x, y, c_in; outputs d, c_out.
  - Instantiated once in the sequencer.

Test Plan (WIDTH=4, WORDS=4, N=16):
- a=16'h1234, b=16'h0235, bin=0, pulse start -> after 4 cycles done=1 for one cycle; diff=16'h0FFF, bout=0, overflow=0; busy high during exactly 4 cycles.
- a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, overflow=0 (borrow ripples through all 4 words).
- a=16'h8000, b=16'h0001, bin=0 -> diff=16'h7FFF, bout=0, overflow=1; then a=16'h7FFF, b=16'hFFFF -> diff=16'h8000, bout=1, overflow=1.
- a=16'h0005, b=16'h0005, bin=1 -> diff=16'hFFFF, bout=1; outputs hold their values until the next completion.
- Pulse start with a=16'h00F0, b=16'h0010; assert start again with other operands at cycle 2 of RUN -> ignored, and the first result diff=16'h00E0 is reported. A start during the done cycle is accepted, and its result follows 4 cycles later.
- Drop rst_n for one edge at cycle 2 of RUN -> busy=0, done never pulses, and diff/bout/overflow=0. A following start completes correctly.

Source files
------------

// File: rtl/multiword_sub_seq_pkg.sv
// Shared types and constants for the word-serial wide subtractor.
// Holds the FSM state encoding and the default slice geometry.
// No logic lives here.
package multiword_sub_seq_pkg;

  // Default slice width and number of words per operand
  localparam int DEF_WIDTH = 4;
  localparam int DEF_WORDS = 4;

  // Word counter width for the default geometry
  localparam int CNT_W = $clog2(DEF_WORDS);

  // Sequencer states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/multiword_sub_seq_sub_slice.sv
// WIDTH-bit ripple-borrow subtractor: d = x - y - c_in, borrow out on c_out.
// Purely combinational, zero latency.
// No flow control; the sequencer drives it every cycle.
import multiword_sub_seq_pkg::*;

module fs_cell (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic d,
  output logic c_out
);
  assign d     = x ^ y ^ c_in;
  assign c_out = (~x & y) | (~(x ^ y) & c_in);
endmodule

module sub_slice #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic [WIDTH-1:0] d,
  output logic             c_out
);

  // Borrow chain: c[i] is the borrow into bit i
  logic [WIDTH:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fs_cell u_cell (
      .x     (x[i]),
      .y     (y[i]),
      .c_in  (c[i]),
      .d     (d[i]),
      .c_out (c[i+1])
    );
  end

  assign c_out = c[WIDTH];

endmodule

// File: rtl/multiword_sub_seq.sv
// Wide a - b - bin computed one WIDTH-bit word per cycle through a shared slice.
// Latency: start sampled at edge k, result and done pulse after edge k+WORDS.
// start is ignored while busy; a start in the done cycle is accepted.
import multiword_sub_seq_pkg::*;

module multiword_sub_seq #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   bin,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] diff,
  output logic                   bout,
  output logic                   overflow
);

  localparam int N  = WIDTH * WORDS;
  localparam int CW = (WORDS > 2) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t state, state_nx;

  logic [N-1:0]       a_sh, b_sh;
  logic [N-WIDTH-1:0] res;       // upper words assembled so far
  logic [CW-1:0]      cnt;
  logic               brw;
  logic               a_msb, b_msb;
  logic               done_q;

  logic [WIDTH-1:0]   s_d;
  logic               s_bo;
  logic [N-1:0]       res_nx;
  logic               last;

  sub_slice #(.WIDTH(WIDTH)) u_slice (
    .x     (a_sh[WIDTH-1:0]),
    .y     (b_sh[WIDTH-1:0]),
    .c_in  (brw),
    .d     (s_d),
    .c_out (s_bo)
  );

  // New slice word enters from the top so the LSW ends at the bottom after WORDS shifts
  assign res_nx = {s_d, res};
  assign last   = (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, word-serial datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      cnt      <= '0;
      brw      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      done_q   <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            a_msb <= a[N-1];
            b_msb <= b[N-1];
          end
        end
        RUN: begin
          res  <= res_nx[N-1:WIDTH];
          brw  <= s_bo;
          a_sh <= a_sh >> WIDTH;
          b_sh <= b_sh >> WIDTH;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff     <= res_nx;
            bout     <= s_bo;
            // Signs differ and the result took the subtrahend's sign
            overflow <= (a_msb != b_msb) && (res_nx[N-1] != a_msb);
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs
  always_comb begin
    busy = (state == RUN);
    done = done_q;
  end

endmodule
